// File: rtl/pulse_pkg.sv
// rtl/pulse_pkg.sv - shared state encoding and default timing constants for pulse_stretcher
package pulse_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   localparam int TICK_DIV_DEF  = 1000;
   localparam int ON_TICKS_DEF  = 200;
   localparam int GAP_TICKS_DEF = 200;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - one-cycle tick every TICK_DIV clocks, phase-aligned to restart
module tick_prescaler
   import pulse_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);

   localparam int            CW   = $clog2(TICK_DIV);
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      tick  = (cnt_q == LAST);
      cnt_d = cnt_q + 1'b1;
      if (restart || tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/pulse_stretcher.sv
// rtl/pulse_stretcher.sv - stretches request pulses into timed high windows with a queued replay
module pulse_stretcher
   import pulse_pkg::*;
#(
   parameter int TICK_DIV  = TICK_DIV_DEF,
   parameter int ON_TICKS  = ON_TICKS_DEF,
   parameter int GAP_TICKS = GAP_TICKS_DEF,
   parameter int PEND_W    = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pulse_in,
   input  logic              clr,
   output logic              out,
   output logic              busy,
   output logic [PEND_W-1:0] pending,
   output logic              overflow
);

   localparam int                TW       = $clog2(max2(ON_TICKS, GAP_TICKS) + 1);
   localparam logic [TW-1:0]     ON_LAST  = TW'(ON_TICKS - 1);
   localparam logic [TW-1:0]     GAP_LAST = TW'(GAP_TICKS - 1);
   localparam logic [PEND_W-1:0] PEND_MAX = '1;

   state_t            state_q, state_d;
   logic              out_q, out_d;
   logic              busy_q, busy_d;
   logic              ovf_q, ovf_d;
   logic [PEND_W-1:0] pend_q, pend_d;
   logic [TW-1:0]     tcnt_q, tcnt_d;

   logic tick;
   logic restart;
   logic phase_done;
   logic dec;
   logic take;
   logic inc;

   tick_prescaler #(
      .TICK_DIV(TICK_DIV)
   ) u_prescaler (
      .clk    (clk),
      .rst    (rst),
      .restart(restart),
      .tick   (tick)
   );

   always_comb begin
      phase_done = 1'b0;
      if (state_q == ST_HIGH) begin
         phase_done = tick && (tcnt_q == ON_LAST);
      end else if (state_q == ST_GAP) begin
         phase_done = tick && (tcnt_q == GAP_LAST);
      end

      // Holding restart through IDLE keeps both counters parked at zero for the next entry.
      restart = (state_q == ST_IDLE) || phase_done;

      tcnt_d = tcnt_q;
      if (restart) begin
         tcnt_d = '0;
      end else if (tick) begin
         tcnt_d = tcnt_q + 1'b1;
      end

      state_d = state_q;
      dec     = 1'b0;
      take    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pulse_in) state_d = ST_HIGH;
         end
         ST_HIGH: begin
            if (phase_done) state_d = ST_GAP;
         end
         ST_GAP: begin
            if (phase_done) begin
               if (pend_q != '0) begin
                  state_d = ST_HIGH;
                  dec     = 1'b1;
               end else if (pulse_in) begin
                  state_d = ST_HIGH;
                  take    = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A request that directly starts the next window is never queued.
      inc = pulse_in && (state_q != ST_IDLE) && !take;

      pend_d = pend_q;
      ovf_d  = 1'b0;
      if (clr) begin
         pend_d = '0;
      end else if (inc && !dec) begin
         if (pend_q == PEND_MAX) begin
            ovf_d = 1'b1;
         end else begin
            pend_d = pend_q + 1'b1;
         end
      end else if (dec && !inc) begin
         pend_d = pend_q - 1'b1;
      end

      out_d  = (state_d == ST_HIGH);
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         out_q   <= 1'b0;
         busy_q  <= 1'b0;
         ovf_q   <= 1'b0;
         pend_q  <= '0;
         tcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         busy_q  <= busy_d;
         ovf_q   <= ovf_d;
         pend_q  <= pend_d;
         tcnt_q  <= tcnt_d;
      end
   end

   assign out      = out_q;
   assign busy     = busy_q;
   assign pending  = pend_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// tb/tb_pulse_stretcher.sv - directed and randomized checks of pulse_stretcher against a cycle-count model
module tb_pulse_stretcher;

   localparam int TICK_DIV  = 4;
   localparam int ON_TICKS  = 3;
   localparam int GAP_TICKS = 2;
   localparam int PEND_W    = 2;
   localparam int ON_CYC    = ON_TICKS * TICK_DIV;
   localparam int GAP_CYC   = GAP_TICKS * TICK_DIV;
   localparam int PMAX      = (1 << PEND_W) - 1;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              pulse_in = 1'b0;
   logic              clr = 1'b0;
   logic              out;
   logic              busy;
   logic [PEND_W-1:0] pending;
   logic              overflow;

   int n_vec = 0;
   int n_err = 0;
   int tstep = 0;

   pulse_stretcher #(
      .TICK_DIV (TICK_DIV),
      .ON_TICKS (ON_TICKS),
      .GAP_TICKS(GAP_TICKS),
      .PEND_W   (PEND_W)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .pulse_in(pulse_in),
      .clr     (clr),
      .out     (out),
      .busy    (busy),
      .pending (pending),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp_v);
      n_vec++;
      if (act != exp_v) begin
         n_err++;
         $display("FAIL %s at step %0d: actual=%0d expected=%0d", name, tstep, act, exp_v);
      end
   endtask

   // Model: each window/gap is simply a count of remaining clock cycles.
   bit m_busy, m_high, m_ovf, m_was_busy, m_dec, m_consumed;
   int m_rem, m_pend;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy = 0; m_high = 0; m_ovf = 0; m_rem = 0; m_pend = 0;
      end else begin
         m_was_busy = m_busy;
         m_dec      = 0;
         m_consumed = 0;
         if (!m_busy) begin
            if (pulse_in) begin m_busy = 1; m_high = 1; m_rem = ON_CYC; end
         end else if (m_rem > 1) begin
            m_rem--;
         end else if (m_high) begin
            m_high = 0; m_rem = GAP_CYC;
         end else if (m_pend > 0) begin
            m_dec = 1; m_high = 1; m_rem = ON_CYC;
         end else if (pulse_in) begin
            m_consumed = 1; m_high = 1; m_rem = ON_CYC;
         end else begin
            m_busy = 0;
         end
         m_ovf = 0;
         if (clr) begin
            m_pend = 0;
         end else if (pulse_in && m_was_busy && !m_consumed) begin
            if (!m_dec) begin
               if (m_pend == PMAX) m_ovf = 1;
               else m_pend++;
            end
         end else if (m_dec) begin
            m_pend--;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         check("model_out", int'(out), int'(m_high));
         check("model_busy", int'(busy), int'(m_busy));
         check("model_pending", int'(pending), m_pend);
         check("model_overflow", int'(overflow), int'(m_ovf));
      end
   end

   task automatic step(input logic p, input logic c);
      pulse_in = p;
      clr      = c;
      @(posedge clk);
      @(negedge clk);
      tstep++;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 300 && busy; i++) step(1'b0, 1'b0);
      check("reach_idle", int'(busy), 0);
   endtask

   task automatic count_high(output int n);
      n = 0;
      while (out && n < 200) begin n++; step(1'b0, 1'b0); end
   endtask

   task automatic count_gap(output int n);
      n = 0;
      while (busy && !out && n < 200) begin n++; step(1'b0, 1'b0); end
   endtask

   int hi, lo, nrise, t_prev;
   int rise[3];
   logic prev_out;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      @(negedge clk);
      check("reset_out", int'(out), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_pending", int'(pending), 0);
      check("reset_overflow", int'(overflow), 0);
      rst = 1'b0;
      steps(3);

      // Single request
      step(1'b1, 1'b0);
      count_high(hi);
      check("single_high_len", hi, 12);
      count_gap(lo);
      check("single_gap_len", lo, 8);
      check("single_idle", int'(busy), 0);

      // Queued requests
      steps(2);
      step(1'b1, 1'b0);
      t_prev = tstep;
      rise[0] = tstep;
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      check("queue_pend1", int'(pending), 1);
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      check("queue_pend2", int'(pending), 2);
      nrise = 1;
      prev_out = out;
      for (int i = 0; i < 200 && busy; i++) begin
         step(1'b0, 1'b0);
         if (out && !prev_out && nrise < 3) begin
            rise[nrise] = tstep;
            nrise++;
            if (nrise == 3) check("queue_pend_third", int'(pending), 0);
         end
         prev_out = out;
      end
      check("queue_rises", nrise, 3);
      check("queue_spacing1", rise[1] - rise[0], 20);
      check("queue_spacing2", rise[2] - rise[1], 20);
      check("queue_first", rise[0], t_prev);
      wait_idle();

      // Overflow
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      check("ovf_pend_sat", int'(pending), 3);
      check("ovf_not_yet", int'(overflow), 0);
      step(1'b1, 1'b0);
      check("ovf_pulse", int'(overflow), 1);
      check("ovf_pend_hold", int'(pending), 3);
      step(1'b0, 1'b0);
      check("ovf_one_cycle", int'(overflow), 0);
      wait_idle();

      // GAP-exit coincidences
      step(1'b1, 1'b0);
      steps(19);
      check("gapx_pre_out", int'(out), 0);
      step(1'b1, 1'b0);
      check("gapx_no_idle_out", int'(out), 1);
      check("gapx_no_idle_busy", int'(busy), 1);
      check("gapx_pend0", int'(pending), 0);
      step(1'b1, 1'b0);
      check("gapx_pend1", int'(pending), 1);
      steps(18);
      step(1'b1, 1'b0);
      check("gapx_net0_pend", int'(pending), 1);
      check("gapx_net0_out", int'(out), 1);
      wait_idle();

      // clr during HIGH
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      check("clr_pend2", int'(pending), 2);
      step(1'b0, 1'b1);
      check("clr_pend0", int'(pending), 0);
      count_high(hi);
      check("clr_rest_of_window", hi, 9);
      count_gap(lo);
      check("clr_gap", lo, 8);
      check("clr_idle", int'(busy), 0);

      // Asynchronous reset mid-window
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      steps(3);
      check("rst_pre_pend", int'(pending), 1);
      #2 rst = 1'b1;
      #1;
      check("rst_async_out", int'(out), 0);
      check("rst_async_busy", int'(busy), 0);
      check("rst_async_pend", int'(pending), 0);
      @(negedge clk);
      rst = 1'b0;
      step(1'b1, 1'b0);
      count_high(hi);
      check("rst_after_high", hi, 12);
      wait_idle();

      // Randomized traffic with varying request density
      for (int blk = 0; blk < 12; blk++) begin
         int dens;
         dens = $urandom_range(1, 12);
         for (int i = 0; i < 180; i++) begin
            if ($urandom_range(0, 599) == 0) begin
               rst = 1'b1;
               step(1'b0, 1'b0);
               rst = 1'b0;
            end else begin
               step(1'($urandom_range(0, dens) == 0), 1'($urandom_range(0, 49) == 0));
            end
         end
      end
      wait_idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
